pwm_decoder: RTL

//   Receive-side counterpart of the PWM generator: measures an incoming PWM waveform
//   and recovers its duty (high time) and period, both in units of step ticks.

---
 rtl/pwm_pkg.sv | 11 +
 rtl/sync_edge.sv | 35 +++
 rtl/pwm_decoder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM types: state encoding for the PWM decoder and for any future
// PWM monitor that follows the same IDLE / MEAS / STUCK measurement flow.
package pwm_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MEAS  = 2'd1,
      S_STUCK = 2'd2
   } pwm_dec_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous input plus a step-qualified level
// register; reports the synchronised value and a rising edge between samples.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic step_i,
   input  logic d_i,
   output logic s_o,
   output logic rise_o
);

   logic meta_q;
   logic s_q;
   logic lvl_q;

   // NOTE: sequential state is written with <= so every flop samples the
   // pre-edge value of its neighbours; blocking here would collapse the chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         s_q    <= 1'b0;
         lvl_q  <= 1'b0;
      end else begin
         meta_q <= d_i;
         s_q    <= meta_q;
         // The level follows every step, even while measurement is disabled,
         // so re-enabling never sees a stale low level and a false rise.
         if (step_i) lvl_q <= s_q;
      end
   end

   assign s_o    = s_q;
   assign rise_o = s_q & ~lvl_q;

endmodule

// File: rtl/pwm_decoder.sv
// Measures an incoming PWM waveform in step ticks: publishes high time and
// period once per rising edge, or a stuck report when no edge arrives in time.
module pwm_decoder
   import pwm_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic         step,
   input  logic         pwm_in,
   output logic [N-1:0] duty,
   output logic [N:0]   period,
   output logic         valid,
   output logic         stuck
);

   localparam int C = N + 1;
   localparam logic [C-1:0] CNT_MAX  = '1;
   localparam logic [C-1:0] CNT_ONE  = C'(1);
   localparam logic [N-1:0] DUTY_MAX = '1;

   logic           s;
   logic           rise;
   pwm_dec_state_t state_q, state_d;
   logic [C-1:0]   per_q, per_d;
   logic [C-1:0]   hi_q, hi_d;
   logic [N-1:0]   duty_q, duty_d;
   logic [C-1:0]   period_q, period_d;
   logic           stuck_q, stuck_d;
   logic           valid_q;
   logic           pub;

   sync_edge u_sync (
      .clk    (clk),
      .rst    (rst),
      .step_i (step),
      .d_i    (pwm_in),
      .s_o    (s),
      .rise_o (rise)
   );

   // NOTE: every signal written here gets a default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      per_d    = per_q;
      hi_d     = hi_q;
      duty_d   = duty_q;
      period_d = period_q;
      stuck_d  = stuck_q;
      pub      = 1'b0;
      if (!ena) begin
         state_d = S_IDLE;
         per_d   = '0;
         hi_d    = '0;
      end else if (step) begin
         case (state_q)
            S_IDLE, S_STUCK: begin
               if (rise) begin
                  state_d = S_MEAS;
                  per_d   = CNT_ONE;
                  hi_d    = CNT_ONE;
               end
            end
            S_MEAS: begin
               // A rise on the timeout sample still closes a normal period.
               if (rise) begin
                  pub      = 1'b1;
                  duty_d   = hi_q[N] ? DUTY_MAX : hi_q[N-1:0];
                  period_d = per_q;
                  stuck_d  = 1'b0;
                  per_d    = CNT_ONE;
                  hi_d     = CNT_ONE;
               end else if (per_q == CNT_MAX) begin
                  pub      = 1'b1;
                  duty_d   = s ? DUTY_MAX : '0;
                  period_d = '0;
                  stuck_d  = 1'b1;
                  state_d  = S_STUCK;
                  per_d    = '0;
                  hi_d     = '0;
               end else begin
                  per_d = per_q + CNT_ONE;
                  if (s && (hi_q != CNT_MAX)) hi_d = hi_q + CNT_ONE;
               end
            end
            default: begin
               state_d = S_IDLE;
               per_d   = '0;
               hi_d    = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         per_q   <= '0;
         hi_q    <= '0;
      end else begin
         state_q <= state_d;
         per_q   <= per_d;
         hi_q    <= hi_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         duty_q   <= '0;
         period_q <= '0;
         stuck_q  <= 1'b0;
      end else begin
         valid_q  <= pub;
         duty_q   <= duty_d;
         period_q <= period_d;
         stuck_q  <= stuck_d;
      end
   end

   assign duty   = duty_q;
   assign period = period_q;
   assign valid  = valid_q;
   assign stuck  = stuck_q;

endmodule
